// File: rtl/qam16_pkg.sv
// Shared types and constants for the 16-QAM hard-decision demapper.
package qam16_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    CALC  = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int BIT_I1 = 3;
  localparam int BIT_Q1 = 2;
  localparam int BIT_I2 = 1;
  localparam int BIT_Q2 = 0;

  localparam int LAST_DEFAULT = 17727;

endpackage

// File: rtl/qam16_thr_calc.sv
// Sequential restoring divide-by-3 of the outer level; commits thr = 2*floor(last/3)
// in one cycle when the W-th quotient bit is produced.
module qam16_thr_calc
  import qam16_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] last,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] thr
);

  localparam int CW = $clog2(W);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  thr_q, thr_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [1:0]    rem_q, rem_d;
  logic [2:0]    trial;
  logic          qbit;

  assign done = busy_q && (cnt_q == CW'(W - 1));
  assign busy = busy_q;
  assign thr  = thr_q;

  // sh_q shifts the dividend out at the top while quotient bits enter at the bottom
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    thr_d  = thr_q;
    sh_d   = sh_q;
    rem_d  = rem_q;
    trial  = {rem_q, sh_q[W-1]};
    qbit   = (trial >= 3'd3);
    if (busy_q) begin
      rem_d = qbit ? 2'(trial - 3'd3) : trial[1:0];
      sh_d  = {sh_q[W-2:0], qbit};
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        busy_d = 1'b0;
        thr_d  = {sh_d[W-2:0], 1'b0};
      end
    end else if (start) begin
      busy_d     = 1'b1;
      cnt_d      = '0;
      rem_d      = '0;
      sh_d       = last;
      sh_d[W-1]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      thr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      thr_q  <= thr_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q  <= sh_d;
    rem_q <= rem_d;
  end

endmodule

// File: rtl/qam16_demapper.sv
// Hard-decision 16-QAM demapper: N lanes of I/Q sliced to Gray bits {I1,Q1,I2,Q2}.
// Optional over-range counter enabled by QAM16_DEMAP_OVRCNT_EN.
module qam16_demapper
  import qam16_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_load,
  input  logic [W-1:0]   last,
  output logic           cfg_busy,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W*N-1:0] I,
  input  logic [W*N-1:0] Q,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*N-1:0] out_bits,
  output logic [15:0]    ovr_cnt
);

  function automatic logic [W-1:0] sat_abs(input logic signed [W-1:0] x);
    logic [W-1:0] r;
    r = $unsigned(x);
    if (x[W-1]) begin
      r = $unsigned(-x);
      if (r[W-1]) r = {1'b0, {(W-1){1'b1}}};
    end
    return r;
  endfunction

  state_e       state_q, state_d;
  logic         calc_start, calc_busy, calc_done;
  logic [W-1:0] thr;
  logic         pipe_en, accept;

  logic         vld_p1_q, vld_p1_d;
  logic         vld_p2_q, vld_p2_d;
  logic [N-1:0] sgn_i_p0, sgn_q_p0;
  logic [W-1:0] mag_i_p0 [N];
  logic [W-1:0] mag_q_p0 [N];
  logic [N-1:0] sgn_i_p1_q, sgn_i_p1_d, sgn_q_p1_q, sgn_q_p1_d;
  logic [W-1:0] mag_i_p1_q [N];
  logic [W-1:0] mag_i_p1_d [N];
  logic [W-1:0] mag_q_p1_q [N];
  logic [W-1:0] mag_q_p1_d [N];
  logic [W-1:0] thr_p1_q, thr_p1_d;
  logic [4*N-1:0] bits_p2_q, bits_p2_d;

  assign calc_start = cfg_load && (state_q != CALC);
  assign pipe_en    = !vld_p2_q || out_ready;
  assign in_ready   = (state_q == RUN) && pipe_en;
  assign accept     = in_valid && in_ready;
  assign cfg_busy   = calc_busy;
  assign out_valid  = vld_p2_q;
  assign out_bits   = bits_p2_q;

  qam16_thr_calc #(.W(W)) u_thr_calc (
    .clk  (clk),
    .rst  (rst),
    .start(calc_start),
    .last (last),
    .busy (calc_busy),
    .done (calc_done),
    .thr  (thr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UNCFG:   if (cfg_load) state_d = CALC;
      CALC:    if (calc_done) state_d = RUN;
      RUN:     if (cfg_load) state_d = CALC;
      default: state_d = UNCFG;
    endcase
  end

  // stage 0: sign and saturated magnitude straight off the input bus
  always_comb begin
    for (int i = 0; i < N; i++) begin
      sgn_i_p0[i] = I[W*i+W-1];
      sgn_q_p0[i] = Q[W*i+W-1];
      mag_i_p0[i] = sat_abs(I[W*i +: W]);
      mag_q_p0[i] = sat_abs(Q[W*i +: W]);
    end
  end

  // stage 1: thr is snapshotted with the beat so a recalculation never reslices it
  always_comb begin
    vld_p1_d   = vld_p1_q;
    sgn_i_p1_d = sgn_i_p1_q;
    sgn_q_p1_d = sgn_q_p1_q;
    mag_i_p1_d = mag_i_p1_q;
    mag_q_p1_d = mag_q_p1_q;
    thr_p1_d   = thr_p1_q;
    if (pipe_en) begin
      vld_p1_d = accept;
      if (accept) begin
        sgn_i_p1_d = sgn_i_p0;
        sgn_q_p1_d = sgn_q_p0;
        mag_i_p1_d = mag_i_p0;
        mag_q_p1_d = mag_q_p0;
        thr_p1_d   = thr;
      end
    end
  end

  // stage 2: threshold compare and output register
  always_comb begin
    vld_p2_d  = vld_p2_q;
    bits_p2_d = bits_p2_q;
    if (pipe_en) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        for (int i = 0; i < N; i++) begin
          bits_p2_d[4*i+BIT_I1] = sgn_i_p1_q[i];
          bits_p2_d[4*i+BIT_Q1] = sgn_q_p1_q[i];
          bits_p2_d[4*i+BIT_I2] = (mag_i_p1_q[i] > thr_p1_q);
          bits_p2_d[4*i+BIT_Q2] = (mag_q_p1_q[i] > thr_p1_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNCFG;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      bits_p2_q <= '0;
    end else begin
      state_q   <= state_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      bits_p2_q <= bits_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    sgn_i_p1_q <= sgn_i_p1_d;
    sgn_q_p1_q <= sgn_q_p1_d;
    mag_i_p1_q <= mag_i_p1_d;
    mag_q_p1_q <= mag_q_p1_d;
    thr_p1_q   <= thr_p1_d;
  end

`ifdef QAM16_DEMAP_OVRCNT_EN
  localparam int HW = $clog2(2*N+1);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [HW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {{(17-HW){1'b0}}, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [W-1:0]  last_q, last_d;
  logic [15:0]   ovr_q, ovr_d;
  logic [HW-1:0] hits;

  // a clear from cfg_load wins over a beat accepted in the same cycle
  always_comb begin
    hits = '0;
    for (int i = 0; i < N; i++) begin
      hits = hits + HW'(mag_i_p0[i] > last_q) + HW'(mag_q_p0[i] > last_q);
    end
    last_d = last_q;
    ovr_d  = ovr_q;
    if (calc_start) begin
      last_d         = last;
      last_d[W-1]    = 1'b0;
      ovr_d          = '0;
    end else if (accept) begin
      ovr_d = sat_add(ovr_q, hits);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= W'(LAST_DEFAULT);
      ovr_q  <= '0;
    end else begin
      last_q <= last_d;
      ovr_q  <= ovr_d;
    end
  end

  assign ovr_cnt = ovr_q;
`else
  assign ovr_cnt = '0;
`endif

endmodule

// File: doc/qam16_demapper.md
# qam16_demapper

Hard-decision 16-QAM demapper: the receive-side inverse of the QAM16 mapper. It slices N parallel signed I/Q samples back into 4-bit Gray-coded symbols, using the same bit convention as the mapper. The slicing threshold is derived on-chip from the outer constellation level `last` by a sequential divide-by-3. The block sits after the receive equaliser/scaler and feeds the bit de-clustering stage through a valid/ready stream.

## Interface
- `N`, 16, number of parallel lanes
- `W`, 16, sample width (two's complement)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_load`  in  1  one-cycle strobe: capture `last` and recompute the threshold
- `last`  in  W  outer constellation level (3·D); bit W-1 is forced to 0
- `cfg_busy`  out  1  high while the threshold is being computed
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`
- `I`  in  W·N  in-phase samples; lane i is bits [W·i+W-1 : W·i]
- `Q`  in  W·N  quadrature samples; same packing as `I`
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts
- `out_bits`  out  4·N  lane i is bits [4i+3 : 4i] = {I1, Q1, I2, Q2}
- `ovr_cnt`  out  16  count of over-range samples (see Configuration)

## Operation
- **Per component decision:**
  - sign bit = 1 → I1/Q1 = 1; sign bit = 0 (including zero) → 0.
  - |x| > thr (strictly greater) → I2/Q2 = 1, else 0.
- **Threshold:** thr = 2·floor(last/3), the midpoint between p1 and last. Default last = 17727 gives p1 = 5909 and thr = 11818.
- **Magnitude:** |x| saturates, so -2^(W-1) maps to 2^(W-1)-1.
- **State machine:**
  - UNCFG → CALC on `cfg_load`.
  - CALC → RUN after W iterations of a restoring divide (one quotient bit per cycle).
  - RUN → CALC on `cfg_load`.
  - `cfg_load` during CALC is ignored.
- **Threshold commit:** `thr` keeps its old value until CALC finishes, then updates in a single cycle.
- **Handshake:**
  - `in_ready` = (state == RUN) && pipeline enable.
  - Pipeline enable = !stage2_valid || `out_ready`.
  - `out_valid` and `out_bits` hold stable while `out_valid && !out_ready`.
- **Pipeline:** two stages with a global stall.
  - Stage 1 registers the sign and saturated |x| per lane.
  - Stage 2 registers the compare against `thr` and drives `out_bits`.
- **Reconfiguration mid-stream:**
  - Beats already in flight drain normally and are sliced with the old `thr`.
  - A beat accepted in the same cycle as `cfg_load` uses the old `thr`.
  - No data is lost or reordered.

## Timing
- **Reset values:** state = UNCFG, `thr` = 0, `in_ready` = 0, `cfg_busy` = 0, `out_valid` = 0, `out_bits` = 0, `ovr_cnt` = 0.
- **Configuration latency:** `cfg_busy` is high W cycles after the `cfg_load` edge. `in_ready` may assert on cycle W+1.
- **Data latency:** a beat accepted at edge k gives `out_valid` = 1 after edge k+2 when not stalled.
- **Throughput:** one beat per cycle under continuous `out_ready`.
- **Stall capacity:** with `out_ready` low, at most 2 beats are held. `in_ready` deasserts once both stages are full.
- **Reset during CALC or with data in flight:** discards everything and returns to UNCFG.

## Configuration
- **Macro:** `QAM16_DEMAP_OVRCNT_EN`.
- **Defined:**
  - `ovr_cnt` counts lane components (I and Q separately) with |x| > `last` on each accepted beat.
  - The count saturates at 0xFFFF.
  - `cfg_load` clears it to 0.
- **Undefined:** `ovr_cnt` is tied to 0 and the counter logic is absent.

## Structure
- **Package `qam16_pkg`:**
  - state enum {UNCFG, CALC, RUN}
  - lane bit positions I1 = 3, Q1 = 2, I2 = 1, Q2 = 0
  - default `LAST_DEFAULT` = 17727
- **Sub-module `qam16_thr_calc`:** a sequential restoring divide-by-3.
  - Inputs: `start`, `last`.
  - Outputs: `busy`, `done`, `thr`.
  - Owns the W-cycle iteration counter.

## Test plan
- Reset, then `cfg_load` with last = 17727 → `cfg_busy` high for 16 cycles, `in_ready` low until cycle 17, internal `thr` = 11818.
- Lane 0: I = +5909, Q = -17727 → lane 0 `out_bits` = 4'b0101, with `out_valid` 2 cycles after acceptance.
- Slicer boundaries, checked on both I and Q:
  - I = 11818 → I2 = 0; I = 11819 → I2 = 1.
  - I = 0 → {I1, I2} = 00.
  - I = -32768 → {I1, I2} = 11.
- Continuous `in_valid` with `out_ready` low for 5 cycles → `in_ready` drops after 2 beats are held. When released, every beat emerges in order with no duplicates or losses.
- `cfg_load` with last = 9000 mid-stream → in-flight beats sliced with 11818. Beats accepted after `in_ready` reasserts use thr = 6000, so I = 6001 → I2 = 1.
- With `QAM16_DEMAP_OVRCNT_EN`:
  - Three components at 20000 → `ovr_cnt` = 3.
  - Forced saturation holds at 0xFFFF.
  - `cfg_load` clears the count.
- Without the macro, `ovr_cnt` stays 0 throughout.
